// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/kill bundle for the RAW-hazard scoreboard.
// master = decode/pipeline side, slave = scoreboard.
interface reg_scoreboard_if #(
    parameter int REG_W   = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 32
) ();
    logic                     issue_valid;
    logic                     issue_ready;
    logic [REG_W-1:0]         issue_dst;
    logic                     issue_dst_en;
    logic [NUM_SRC*REG_W-1:0] issue_src;
    logic [NUM_SRC-1:0]       issue_src_en;
    logic                     wb_valid;
    logic [REG_W-1:0]         wb_dst;
    logic                     kill_valid;
    logic [REG_W-1:0]         kill_dst;
    logic [NUM_SRC-1:0]       fwd_hit;
    logic [REG_W+CNT_W-1:0]   inflight;
    logic [STALL_W-1:0]       stall_cycles;
    logic                     err;

    modport master (
        output issue_valid, issue_dst, issue_dst_en,
        output issue_src, issue_src_en,
        output wb_valid, wb_dst, kill_valid, kill_dst,
        input  issue_ready, fwd_hit, inflight,
        input  stall_cycles, err
    );

    modport slave (
        input  issue_valid, issue_dst, issue_dst_en,
        input  issue_src, issue_src_en,
        input  wb_valid, wb_dst, kill_valid, kill_dst,
        output issue_ready, fwd_hit, inflight,
        output stall_cycles, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// RAW-hazard scoreboard: per-register pending-write counters gating issue.
// Define SB_BYPASS_EN to let a same-cycle writeback satisfy a source.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int CNT_W    = 2,
    parameter int STALL_W  = 32
) (
    input logic              clk,
    input logic              reset,
    reg_scoreboard_if.slave  sb
);
    localparam int IW = REG_W + CNT_W;
    localparam int NW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);
    localparam logic signed [NW-1:0] N_ONE = NW'(1);

    logic [CNT_W-1:0]   cnt_q [NUM_REGS];
    logic [CNT_W-1:0]   cnt_d [NUM_REGS];
    logic [IW-1:0]      inflight_q, inflight_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    logic [REG_W-1:0]   src [NUM_SRC];
    logic [NUM_SRC-1:0] pend, byp, hazard;
    logic               sat, ready, fire;

    always_comb begin : issue_check
        pend = '0;
        byp  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src[i]  = sb.issue_src[i*REG_W +: REG_W];
            pend[i] = sb.issue_src_en[i] && src[i] != '0
                      && cnt_q[src[i]] != '0;
`ifdef SB_BYPASS_EN
            byp[i]  = cnt_q[src[i]] == CONE && sb.wb_valid
                      && sb.wb_dst == src[i];
`else
            byp[i]  = 1'b0;
`endif
        end
        hazard = pend & ~byp;
        sat    = sb.issue_dst_en && sb.issue_dst != '0
                 && cnt_q[sb.issue_dst] == CMAX;
        ready  = !(|hazard) && !sat;
        fire   = sb.issue_valid && ready && sb.issue_dst_en
                 && sb.issue_dst != '0;
    end

    logic signed [NW-1:0] nxt, dlt;
    logic [IW-1:0]        delta;
    logic                 err_set;

    // Every event on a register folds into one net update, clamped at both ends.
    always_comb begin : count_next
        err_set = 1'b0;
        delta   = '0;
        nxt     = '0;
        dlt     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                nxt = $signed({2'b00, cnt_q[r]});
                if (fire && sb.issue_dst == REG_W'(r))
                    nxt = nxt + N_ONE;
                if (sb.wb_valid && sb.wb_dst == REG_W'(r))
                    nxt = nxt - N_ONE;
                if (sb.kill_valid && sb.kill_dst == REG_W'(r))
                    nxt = nxt - N_ONE;
                if (nxt[NW-1]) begin
                    cnt_d[r] = '0;
                    err_set  = 1'b1;
                end else if (nxt[NW-2]) begin
                    cnt_d[r] = CMAX;
                    err_set  = 1'b1;
                end else begin
                    cnt_d[r] = nxt[CNT_W-1:0];
                end
                dlt   = $signed({2'b00, cnt_d[r]})
                        - $signed({2'b00, cnt_q[r]});
                delta = delta + {{(IW-NW){dlt[NW-1]}}, dlt};
            end
        end
        inflight_d = inflight_q + delta;
        stall_d    = stall_q;
        if (sb.issue_valid && !ready && stall_q != '1)
            stall_d = stall_q + STALL_W'(1);
        err_d = err_q | err_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
            inflight_q <= '0;
            stall_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
            inflight_q <= inflight_d;
            stall_q    <= stall_d;
            err_q      <= err_d;
        end
    end

    assign sb.issue_ready  = ready;
    assign sb.fwd_hit      = byp & pend;
    assign sb.inflight     = inflight_q;
    assign sb.stall_cycles = stall_q;
    assign sb.err          = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed scenarios plus random
// traffic checked against a counter-array reference model.
module tb_reg_scoreboard;
`ifdef SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_scoreboard_if #(
        .REG_W(5), .NUM_SRC(2), .CNT_W(2), .STALL_W(32)
    ) sb ();

    reg_scoreboard #(
        .NUM_REGS(32), .REG_W(5), .NUM_SRC(2),
        .CNT_W(2), .STALL_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sb(sb)
    );

    typedef struct {
        logic       rdy;
        logic [1:0] fh;
        int         infl;
        int         stall;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t expq[$];
    int   mc[32];
    int   m_stall = 0;
    bit   m_err = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;

    function automatic void chk(string nm, int c,
                                longint got, longint want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                      nm, c, got, want);
    endfunction

    function automatic void clear_model();
        foreach (mc[r]) mc[r] = 0;
        m_stall = 0;
        m_err = 1'b0;
    endfunction

    task automatic drive_idle();
        sb.issue_valid  = 1'b0;
        sb.issue_dst    = '0;
        sb.issue_dst_en = 1'b0;
        sb.issue_src    = '0;
        sb.issue_src_en = '0;
        sb.wb_valid     = 1'b0;
        sb.wb_dst       = '0;
        sb.kill_valid   = 1'b0;
        sb.kill_dst     = '0;
    endtask

    task automatic step(input bit iv, input int d, input bit de,
                        input int s0, input int s1, input bit [1:0] se,
                        input bit wv, input int wd,
                        input bit kv, input int kd);
        exp_t e;
        int   net[32];
        int   s;
        int   sum;
        bit   hz;
        bit   sat;
        logic [1:0] fh;
        sb.issue_valid  = iv;
        sb.issue_dst    = 5'(d);
        sb.issue_dst_en = de;
        sb.issue_src    = {5'(s1), 5'(s0)};
        sb.issue_src_en = se;
        sb.wb_valid     = wv;
        sb.wb_dst       = 5'(wd);
        sb.kill_valid   = kv;
        sb.kill_dst     = 5'(kd);
        hz = 1'b0;
        fh = '0;
        for (int i = 0; i < 2; i++) begin
            s = (i == 0) ? s0 : s1;
            if (se[i] && s != 0 && mc[s] != 0) begin
                if (BYP && mc[s] == 1 && wv && wd == s) fh[i] = 1'b1;
                else hz = 1'b1;
            end
        end
        sat = de && d != 0 && mc[d] == 3;
        sum = 0;
        foreach (mc[r]) sum += mc[r];
        e.rdy   = !hz && !sat;
        e.fh    = fh;
        e.infl  = sum;
        e.stall = m_stall;
        e.err   = m_err;
        e.cyc   = cyc;
        expq.push_back(e);
        if (iv && !e.rdy) m_stall++;
        foreach (net[r]) net[r] = 0;
        if (iv && e.rdy && de && d != 0) net[d]++;
        if (wv && wd != 0) net[wd]--;
        if (kv && kd != 0) net[kd]--;
        for (int r = 1; r < 32; r++) begin
            mc[r] += net[r];
            if (mc[r] < 0) begin
                mc[r] = 0;
                m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    // Reset lands between edges; outputs must clear before the next edge.
    task automatic async_reset();
        exp_t e;
        drive_idle();
        #1;
        reset = 1'b0;
        clear_model();
        e.rdy = 1'b1; e.fh = '0; e.infl = 0;
        e.stall = 0; e.err = 1'b0; e.cyc = cyc;
        expq.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("issue_ready", e.cyc, sb.issue_ready, e.rdy);
            chk("fwd_hit", e.cyc, sb.fwd_hit, e.fh);
            chk("inflight", e.cyc, sb.inflight, e.infl);
            chk("stall_cycles", e.cyc, sb.stall_cycles, e.stall);
            chk("err", e.cyc, sb.err, e.err);
        end
    end

    initial begin
        bit iv, de, wv, kv;
        int d, s0, s1, wd, kd;
        bit [1:0] se;
        clear_model();
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        // dependent instruction on x5, then writeback of x5
        step(1, 5, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 6, 1, 5, 0, 2'b01, 0, 0, 0, 0);
        step(1, 6, 1, 5, 0, 2'b01, 1, 5, 0, 0);
        step(1, 6, 1, 5, 0, 2'b01, 0, 0, 0, 0);
        while (mc[6] > 0) step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 6);
        // saturate x7
        repeat (3) step(1, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 7, 1, 0, 0, 2'b00, 1, 7, 0, 0);
        step(1, 7, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        while (mc[7] > 0) step(0, 0, 0, 0, 0, 2'b00, 1, 7, 0, 0);
        // issue and writeback on x3 in one cycle
        step(1, 3, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 2'b00, 1, 3, 0, 0);
        step(0, 0, 0, 0, 0, 2'b00, 1, 3, 0, 0);
        // register 0 is ignored everywhere
        step(1, 0, 1, 0, 0, 2'b11, 1, 0, 1, 0);
        idle();
        // underflow makes err sticky
        step(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 9);
        idle();
        idle();
        // four outstanding writes then async reset
        for (int r = 10; r < 14; r++)
            step(1, r, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        idle();
        async_reset();
        idle();
        for (int n = 0; n < 1500; n++) begin
            if (n == 750) async_reset();
            iv = $urandom_range(0, 9) < 7;
            de = $urandom_range(0, 9) < 8;
            d  = $urandom_range(0, 7);
            s0 = $urandom_range(0, 7);
            s1 = $urandom_range(0, 7);
            se = 2'($urandom_range(0, 3));
            wd = $urandom_range(0, 7);
            kd = $urandom_range(0, 7);
            wv = $urandom_range(0, 9) < 4
                 && (mc[wd] > 0 || $urandom_range(0, 19) == 0);
            kv = $urandom_range(0, 19) < 3
                 && (mc[kd] > 0 || $urandom_range(0, 19) == 0);
            step(iv, d, de, s0, s1, se, wv, wd, kv, kd);
        end
        idle();
        @(negedge clk);
        #1;
        chk("drain", cyc, expq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
